// File: rtl/uart_transmitter_pkg.sv
// uart_transmitter_pkg: shared UART state encoding, oversampling constant and defaults
package uart_transmitter_pkg;
  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
  function automatic int cnt_w(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_transmitter_parity.sv
// uart_parity: even/odd parity of a data word, shared by transmitter and receiver
module uart_parity #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic         odd,
  output logic         parity
);
  assign parity = (^data) ^ odd;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one word LSB-first with start, optional parity and stop bits on a 16x tick
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DBIT       = DEF_DBIT,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_dataIn,
  output logic            tx_doneTick,
  output logic            tx_busy,
  output logic            tx
);
  localparam int SW = cnt_w(SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_END    = NW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            par_new;
  logic            stop_end;

  uart_parity #(.W(DBIT)) u_parity (
    .data   (tx_dataIn),
    .odd    (PARITY_ODD != 0),
    .parity (par_new)
  );

  always_comb begin
    state_d  = state_q;
    s_cnt_d  = s_cnt_q;
    n_cnt_d  = n_cnt_q;
    b_d      = b_q;
    par_d    = par_q;
    stop_end = 1'b0;
    case (state_q)
      IDLE: if (tx_start) begin
        state_d = START;
        s_cnt_d = '0;
        b_d     = tx_dataIn;
        par_d   = par_new;
      end
      START: if (s_tick) begin
        if (s_cnt_q == BIT_END) begin
          state_d = DATA;
          s_cnt_d = '0;
          n_cnt_d = '0;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      DATA: if (s_tick) begin
        if (s_cnt_q == BIT_END) begin
          s_cnt_d = '0;
          b_d     = b_q >> 1;
          n_cnt_d = n_cnt_q + 1'b1;
          if (n_cnt_q == N_END) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      PARITY: if (s_tick) begin
        if (s_cnt_q == BIT_END) begin
          state_d = STOP;
          s_cnt_d = '0;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      STOP: if (s_tick) begin
        if (s_cnt_q == STOP_END) begin
          state_d  = IDLE;
          s_cnt_d  = '0;
          stop_end = 1'b1;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // line level follows the next state so it is already correct on the edge that enters it
    tx_d = (state_d == START)  ? 1'b0 :
           (state_d == DATA)   ? b_d[0] :
           (state_d == PARITY) ? par_d : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // done is issued during the final stop tick so the fifo pop lands on the IDLE edge
  assign tx_doneTick = stop_end & ~reset;
  assign tx_busy     = (state_q != IDLE);
  assign tx          = tx_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of framing, parity, fifo burst, reset abort and abuse cases
module tb_uart_transmitter;
  logic       clk = 1'b0, reset = 1'b1, s_tick = 1'b0, tick_en = 1'b1;
  logic       tx_start = 1'b0, p_start = 1'b0;
  logic [7:0] tx_dataIn = 8'h00, p_data = 8'h00;
  logic       tx0, tx1, tx2, dn0, dn1, dn2, bz0, bz1, bz2;
  logic [2:0] tx_a, done_a, busy_a;
  logic [7:0] q[$];
  int         cmp = 0, errs = 0, tcnt = 0, done_cnt = 0, gap = 0, dc = 0;

  assign tx_a   = {tx2, tx1, tx0};
  assign done_a = {dn2, dn1, dn0};
  assign busy_a = {bz2, bz1, bz0};

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_dataIn(tx_dataIn),
    .tx_doneTick(dn0), .tx_busy(bz0), .tx(tx0));
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(p_start), .tx_dataIn(p_data),
    .tx_doneTick(dn1), .tx_busy(bz1), .tx(tx1));
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(p_start), .tx_dataIn(p_data),
    .tx_doneTick(dn2), .tx_busy(bz2), .tx(tx2));

  initial forever begin
    @(posedge clk);
    #1;
    tcnt   = (tcnt + 1) % 4;
    s_tick = tick_en && (tcnt == 0);
  end

  initial forever begin
    @(negedge clk);
    if (dn0) done_cnt++;
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    cmp++;
    assert (got == exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [7:0] d, input bit pe, input logic pb);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pe) f[9] = pb;
    return f;
  endfunction

  task automatic idle_check(input string tag, input int ncyc);
    logic bad;
    bad = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0) bad = 1'b1;
    end
    chk(tag, bad, 1'b0);
  endtask

  // act: 0 none, 1 new data + start pulse, 2 stall ticks 1000 clk, 3 reset abort
  task automatic check_frame(input string tag, input int sel, input logic [11:0] exp,
                             input int nb, input int total, input int act, input int act_n,
                             input bit fifo, output int gp);
    int   n, idx, to;
    bit   clr, acted, ok;
    logic hold, bad;
    n = 0; idx = 0; to = 0; clr = 0; acted = 0; ok = 0;
    while (tx_a[sel] !== 1'b0 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    gp = to;
    if (to >= 3000) begin
      chki({tag, " start timeout"}, to, 0);
      return;
    end
    to = 0;
    while (to < 20000) begin
      if (clr) begin
        tx_start = 1'b0;
        clr      = 0;
      end
      if (idx < nb && n == 16 * idx + 8) begin
        chk($sformatf("%s bit%0d", tag, idx), tx_a[sel], exp[idx]);
        idx++;
      end
      if (done_a[sel]) begin
        ok = 1;
        break;
      end
      if (act != 0 && !acted && n == act_n) begin
        acted = 1;
        if (act == 1) begin
          tx_dataIn = ~tx_dataIn;
          tx_start  = 1'b1;
          clr       = 1;
        end else if (act == 2) begin
          if (s_tick) n++;
          tick_en = 1'b0;
          @(posedge clk);
          #2;
          hold = tx_a[sel];
          bad  = 1'b0;
          repeat (1000) begin
            @(negedge clk);
            if (tx_a[sel] !== hold || busy_a[sel] !== 1'b1) bad = 1'b1;
          end
          chk({tag, " stall hold"}, bad, 1'b0);
          tick_en = 1'b1;
        end else begin
          reset = 1'b1;
          @(negedge clk);
          chk({tag, " abort tx"}, tx_a[sel], 1'b1);
          chk({tag, " abort done"}, done_a[sel], 1'b0);
          chk({tag, " abort busy"}, busy_a[sel], 1'b0);
          reset = 1'b0;
          return;
        end
      end
      if (s_tick) n++;
      @(negedge clk);
      to++;
    end
    if (!ok) begin
      chki({tag, " done timeout"}, to, 0);
      return;
    end
    chki({tag, " ticks"}, n + 1, total);
    chki({tag, " bits seen"}, idx, nb);
    @(negedge clk);
    chk({tag, " busy after"}, busy_a[sel], 1'b0);
    chk({tag, " tx after"}, tx_a[sel], 1'b1);
    chk({tag, " done width"}, done_a[sel], 1'b0);
    if (fifo) begin
      void'(q.pop_front());
      tx_start  = (q.size() != 0);
      tx_dataIn = (q.size() != 0) ? q[0] : 8'h00;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst tx", tx_a[0], 1'b1);
    chk("rst busy", busy_a[0], 1'b0);
    chk("rst done", done_a[0], 1'b0);
    reset = 1'b0;
    idle_check("idle line", 60);

    tx_dataIn = 8'h55;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("f55", 0, mk(8'h55, 0, 1'b0), 10, 160, 0, 0, 0, gap);
    chki("f55 start latency", gap, 0);

    p_data  = 8'hF0;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    check_frame("pe_f0", 1, mk(8'hF0, 1, 1'b0), 11, 176, 0, 0, 0, gap);
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    check_frame("po_f0", 2, mk(8'hF0, 1, 1'b1), 11, 176, 0, 0, 0, gap);

    q  = '{8'hFF, 8'h0F, 8'hAA};
    dc = done_cnt;
    tx_dataIn = q[0];
    tx_start  = 1'b1;
    check_frame("bst_ff", 0, mk(8'hFF, 0, 1'b0), 10, 160, 0, 0, 1, gap);
    check_frame("bst_0f", 0, mk(8'h0F, 0, 1'b0), 10, 160, 0, 0, 1, gap);
    chki("bst gap 2", gap, 1);
    check_frame("bst_aa", 0, mk(8'hAA, 0, 1'b0), 10, 160, 0, 0, 1, gap);
    chki("bst gap 3", gap, 1);
    chki("bst done pulses", done_cnt - dc, 3);
    idle_check("bst idle", 100);

    dc = done_cnt;
    tx_dataIn = 8'h00;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("abort00", 0, mk(8'h00, 0, 1'b0), 10, 160, 3, 68, 0, gap);
    idle_check("abort idle", 100);
    chki("abort no done", done_cnt - dc, 0);
    tx_dataIn = 8'h81;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("f81", 0, mk(8'h81, 0, 1'b0), 10, 160, 0, 0, 0, gap);

    tx_dataIn = 8'h3C;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("chg3c", 0, mk(8'h3C, 0, 1'b0), 10, 160, 1, 36, 0, gap);
    idle_check("chg ignored", 100);

    tx_dataIn = 8'hA5;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("stall_a5", 0, mk(8'hA5, 0, 1'b0), 10, 160, 2, 52, 0, gap);
    idle_check("final idle", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
